// File: rtl/sar_avg_dec.sv
// sar_avg_dec: sequences a SAR converter through N = 2**Log2N conversions,
// accumulates the results and publishes their truncated mean. While en_i is
// high, blocks of conversions run back to back. Each conversion has a WAIT
// cycle budget; if the budget runs out, a sticky error flag is raised.
// Log2N must be at least 1.
module sar_avg_dec #(
  parameter int Width         = 6,
  parameter int Log2N         = 2,
  parameter int TimeoutCycles = 63
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             eoc_i,
  input  logic [Width-1:0] result_i,
  output logic             start_o,
  output logic [Width-1:0] avg_o,
  output logic             valid_o,
  output logic             busy_o,
  output logic             err_o
);

  localparam int AccW = Width + Log2N;
  localparam int TmoW = $clog2(TimeoutCycles + 1);

  localparam logic [TmoW-1:0] TmoLast = TmoW'(TimeoutCycles - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] OUT   = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [AccW-1:0]  acc_q, acc_d;
  logic [Log2N-1:0] cnt_q, cnt_d;
  logic [TmoW-1:0]  tmo_q, tmo_d;
  logic [Width-1:0] avg_q, avg_d;
  logic             err_q, err_d;
  logic             eoc_q;
  logic             start_q;
  logic             valid_q;
  logic             busy_q;
  logic             eoc_edge;

  // A sample arrives only on a rising eoc_i edge, so a long eoc_i pulse is one sample.
  assign eoc_edge = eoc_i & ~eoc_q;

  // Next-state and datapath logic for the acquisition sequencer.
  always_comb begin
    // NOTE: every signal gets a default first, so no branch can leave one unassigned and infer a latch.
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    avg_d   = avg_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (en_i) state_d = START;
      end

      START: begin
        if (!en_i) begin
          acc_d   = '0;
          cnt_d   = '0;
          tmo_d   = '0;
          state_d = IDLE;
        end else begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (!en_i) begin
          // The abort wins over a coinciding eoc edge, so that sample is dropped.
          acc_d   = '0;
          cnt_d   = '0;
          tmo_d   = '0;
          state_d = IDLE;
        end else if (eoc_edge) begin
          acc_d = acc_q + AccW'(result_i);
          cnt_d = cnt_q + Log2N'(1);
          tmo_d = '0;
          if (&cnt_q) begin
            // Load the mean on entry to OUT so avg_o and valid_o change together.
            avg_d   = acc_d[AccW-1:Log2N];
            state_d = OUT;
          end else begin
            state_d = START;
          end
        end else if (tmo_q == TmoLast) begin
          err_d   = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          tmo_d   = '0;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end

      OUT: begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = en_i ? START : IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers; outputs are decoded from the next state so they align with it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      avg_q   <= '0;
      err_q   <= 1'b0;
      eoc_q   <= 1'b0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register here sample pre-edge values, whatever the statement order.
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      avg_q   <= avg_d;
      err_q   <= err_d;
      eoc_q   <= eoc_i;
      start_q <= (state_d == START);
      valid_q <= (state_d == OUT);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign start_o = start_q;
  assign avg_o   = avg_q;
  assign valid_o = valid_q;
  assign busy_o  = busy_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_sar_avg_dec.sv
// tb_sar_avg_dec: the bench acts as the upstream SAR converter. It answers
// each start_o with an eoc_i pulse after a random delay and hold time. It
// predicts each average as the plain sum of the samples it delivered divided
// by N, and checks the protocol timing of start_o, valid_o, busy_o and err_o
// around each event.
module tb_sar_avg_dec;

  localparam int Width = 6;
  localparam int Log2N = 2;
  localparam int N     = 1 << Log2N;
  localparam int Tmo   = 63;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             en_i;
  logic             eoc_i;
  logic [Width-1:0] result_i;
  logic             start_o;
  logic [Width-1:0] avg_o;
  logic             valid_o;
  logic             busy_o;
  logic             err_o;

  int n_checks  = 0;
  int n_pass    = 0;
  int hold_left = 0;
  bit dropped_now = 1'b0;
  int last_avg  = 0;

  sar_avg_dec #(.Width(Width), .Log2N(Log2N), .TimeoutCycles(Tmo)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (en_i),
    .eoc_i   (eoc_i),
    .result_i(result_i),
    .start_o (start_o),
    .avg_o   (avg_o),
    .valid_o (valid_o),
    .busy_o  (busy_o),
    .err_o   (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Advance to the next falling edge, where inputs are driven and outputs sampled.
  task automatic tick();
    @(negedge clk_i);
    dropped_now = 1'b0;
    if (hold_left > 0) begin
      hold_left--;
      if (hold_left == 0) begin
        eoc_i       = 1'b0;
        dropped_now = 1'b1;
      end
    end
  endtask

  task automatic wait_start();
    int k = 0;
    while (!start_o && k < 40) begin
      tick();
      k++;
    end
    check("start_seen", int'(start_o), 1);
  endtask

  // Called at the falling edge where start_o is high; delivers one conversion.
  task automatic sample(input int v, input int dly, input int hold, input bit last, input int exp_avg);
    int k = 0;
    do begin
      tick();
      k++;
      if (k == 1) check("start_width", int'(start_o), 0);
    end while (k < dly || eoc_i || dropped_now);
    result_i  = Width'(v);
    eoc_i     = 1'b1;
    hold_left = hold;
    tick();
    if (last) begin
      check("valid_pulse", int'(valid_o), 1);
      check("avg_value", int'(avg_o), exp_avg);
      last_avg = exp_avg;
      tick();
      check("valid_width", int'(valid_o), 0);
      check("restart_after_valid", int'(start_o), 1);
    end else begin
      check("next_start", int'(start_o), 1);
      check("no_early_valid", int'(valid_o), 0);
      check("avg_held", int'(avg_o), last_avg);
    end
  endtask

  task automatic run_block(input int vals[4], input int hold);
    int sum = 0;
    for (int i = 0; i < N; i++) sum += vals[i];
    if (!start_o) wait_start();
    for (int i = 0; i < N; i++)
      sample(vals[i], int'($urandom_range(1, 4)), hold, (i == N - 1), sum / N);
  endtask

  task automatic run_random_block();
    int vals[4];
    for (int i = 0; i < N; i++) vals[i] = int'($urandom_range(0, 63));
    run_block(vals, int'($urandom_range(1, 5)));
  endtask

  // Settle into WAIT with eoc_i low after a sample's start_o.
  task automatic enter_wait();
    do tick(); while (eoc_i || dropped_now);
  endtask

  initial begin
    rst_i    = 1'b1;
    en_i     = 1'b0;
    eoc_i    = 1'b0;
    result_i = '0;
    repeat (2) @(negedge clk_i);
    check("rst_start", int'(start_o), 0);
    check("rst_avg", int'(avg_o), 0);
    check("rst_valid", int'(valid_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_err", int'(err_o), 0);
    rst_i = 1'b0;
    tick();
    check("idle_busy", int'(busy_o), 0);
    en_i = 1'b1;
    check("no_start_before_edge", int'(start_o), 0);

    // Directed mean and full-scale blocks.
    run_block('{10, 11, 12, 13}, 1);
    run_block('{63, 63, 63, 63}, 1);
    for (int b = 0; b < 3; b++) run_random_block();

    // eoc_i held high across the following START/WAIT counts once.
    run_block('{20, 30, 40, 50}, 5);

    // Timeout: answer nothing and watch the WAIT budget expire.
    run_block('{1, 2, 3, 4}, 1);
    for (int i = 1; i <= Tmo; i++) begin
      tick();
      if (i == Tmo) begin
        check("tmo_not_yet_err", int'(err_o), 0);
        check("tmo_not_yet_busy", int'(busy_o), 1);
      end
    end
    tick();
    check("tmo_err", int'(err_o), 1);
    check("tmo_idle", int'(busy_o), 0);
    run_block('{4, 4, 4, 4}, 1);
    check("err_sticky", int'(err_o), 1);

    // Abort after two samples, with an eoc edge on the abort cycle.
    if (!start_o) wait_start();
    sample(5, 1, 1, 1'b0, 0);
    sample(7, 2, 1, 1'b0, 0);
    enter_wait();
    en_i      = 1'b0;
    result_i  = 6'd63;
    eoc_i     = 1'b1;
    hold_left = 1;
    tick();
    check("abort_idle", int'(busy_o), 0);
    check("abort_no_valid", int'(valid_o), 0);
    repeat (3) begin
      tick();
      check("abort_quiet", int'(valid_o) + int'(start_o), 0);
    end
    en_i = 1'b1;
    run_block('{8, 8, 8, 8}, 1);

    // Asynchronous reset in WAIT with a partial sum.
    if (!start_o) wait_start();
    sample(50, 1, 1, 1'b0, 0);
    sample(50, 1, 1, 1'b0, 0);
    enter_wait();
    #2 rst_i = 1'b1;
    #1;
    check("arst_start", int'(start_o), 0);
    check("arst_avg", int'(avg_o), 0);
    check("arst_busy", int'(busy_o), 0);
    check("arst_err", int'(err_o), 0);
    check("arst_valid", int'(valid_o), 0);
    en_i      = 1'b0;
    eoc_i     = 1'b0;
    hold_left = 0;
    tick();
    rst_i = 1'b0;
    repeat (2) tick();
    result_i  = 6'd33;
    eoc_i     = 1'b1;
    hold_left = 2;
    repeat (3) begin
      tick();
      check("idle_eoc_ignored", int'(busy_o) + int'(valid_o) + int'(start_o), 0);
    end
    check("idle_eoc_avg", int'(avg_o), 0);
    last_avg = 0;
    en_i = 1'b1;
    run_random_block();
    run_random_block();
    check("err_after_reset", int'(err_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sar_avg_dec.md
SAR_AVG_DEC -- requirements
Module: sar_avg_dec

Interface
REQ-001 SHALL have parameter Width, default 6, meaning the bit width of each conversion result.
REQ-002 SHALL have parameter Log2N, default 2, meaning log2 of the number of samples averaged per output (N = 2^Log2N).
REQ-003 SHALL have parameter TimeoutCycles, default 63, meaning the maximum number of WAIT cycles allowed per conversion.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port en_i, input, 1 bit: level; run continuous averaged acquisition while high.
REQ-007 SHALL have port eoc_i, input, 1 bit: end-of-conversion from the upstream SAR FSM; level input, edge-detected internally.
REQ-008 SHALL have port result_i, input, Width bits: conversion result; valid on the cycle a rising eoc_i edge is detected.
REQ-009 SHALL have port start_o, output, 1 bit: one-cycle conversion request to the SAR FSM.
REQ-010 SHALL have port avg_o, output, Width bits: last averaged result; held until the next update.
REQ-011 SHALL have port valid_o, output, 1 bit: one-cycle pulse when avg_o updates.
REQ-012 SHALL have port busy_o, output, 1 bit: high in any state other than IDLE.
REQ-013 SHALL have port err_o, output, 1 bit: sticky timeout flag.

Function
REQ-014 SHALL implement states IDLE, START, WAIT, OUT.
REQ-015 SHALL register eoc_i into eoc_q each cycle; an eoc edge is eoc_i=1 and eoc_q=0.
REQ-016 SHALL transition IDLE->START when en_i=1; otherwise remain in IDLE.
REQ-017 SHALL drive start_o=1 for exactly the one cycle spent in START, then transition START->WAIT.
REQ-018 SHALL, in WAIT on an eoc edge, add zero-extended result_i to the accumulator (Width+Log2N bits, never overflows), increment the sample counter (Log2N bits), and reset the timeout counter.
REQ-019 SHALL, on that WAIT edge, go to OUT if the counter was N-1 before the increment, else to START.
REQ-020 SHALL, in OUT: load avg_o with accumulator bits [Width+Log2N-1:Log2N] (truncating divide), pulse valid_o for that cycle, clear the accumulator and counter, then go to START if en_i=1, else IDLE.
REQ-021 SHALL, when en_i=0 in START or WAIT, abort: clear the accumulator, counter and timeout counter, go to IDLE next cycle, with no valid_o; an eoc edge coinciding with the abort SHALL be discarded.
REQ-022 SHALL count WAIT cycles without an eoc edge; on reaching TimeoutCycles it SHALL set err_o, clear the accumulator and counter, and go to IDLE.
REQ-023 SHALL clear err_o only by reset; the FSM SHALL restart normally from IDLE while err_o=1.
REQ-024 SHALL ignore eoc edges in IDLE, START and OUT.
REQ-025 SHALL give latency from the N-th eoc edge to valid_o of exactly 1 cycle; with en_i held high, the next start_o SHALL occur the cycle after valid_o.
REQ-026 SHALL drive all outputs from registers.

Reset
REQ-027 SHALL, while rst_i=1 (asynchronous, at any point including mid-conversion), force: state=IDLE, accumulator=0, counters=0, eoc_q=0, start_o=0, avg_o=0, valid_o=0, busy_o=0, err_o=0.
REQ-028 SHALL, after rst_i falls, first issue start_o no earlier than the second rising edge with en_i=1.

Verification
REQ-029 Width=6, Log2N=2, en_i=1, results 10,11,12,13 on four eoc edges -> four start_o pulses, then avg_o=11, valid_o high exactly 1 cycle, 1 cycle after the 4th edge.
REQ-030 Four results of 63 -> avg_o=63, no wrap; with en_i still high, start_o is asserted the cycle after valid_o.
REQ-031 No eoc edge for 63 WAIT cycles -> err_o=1 and return to IDLE; the next block of 4,4,4,4 -> avg_o=4 while err_o stays 1.
REQ-032 en_i dropped after 2 of 4 samples -> IDLE, no valid_o; re-enable with 8,8,8,8 -> avg_o=8 (no stale sum).
REQ-033 rst_i asserted in WAIT with accumulator non-zero -> all outputs 0 immediately; an eoc edge in IDLE afterwards has no effect.
REQ-034 eoc_i held high for 5 cycles in WAIT -> counted as a single sample.
